// File: rtl/ca_pkg.sv
// ca_pkg: shared geometry, seed row and FSM encoding for the cellular-automaton frame generator.
package ca_pkg;
    localparam int WORD_W        = 20;
    localparam int WORDS_PER_ROW = 64;
    localparam int ROWS          = 1024;
    localparam int SEED_WORD_IDX = 32;
    localparam logic [19:0] SEED_WORD = 20'h00001;
    typedef enum logic {IDLE, GEN} state_t;
endpackage

// File: rtl/ca_word_next.sv
// ca_word_next: applies an elementary CA rule to one word of cells, given the
// outer neighbour bits; bit 0 is the leftmost cell.
module ca_word_next #(
    parameter int WORD_W = ca_pkg::WORD_W
) (
    input  logic [7:0]        rule,
    input  logic [WORD_W-1:0] old_word,
    input  logic              left_bit,
    input  logic              right_bit,
    output logic [WORD_W-1:0] next_word
);
    import ca_pkg::*;
    logic [WORD_W+1:0] w_ext;
    assign w_ext = {right_bit, old_word, left_bit};
    always_comb begin
        next_word = '0;
        for (int i = 0; i < WORD_W; i++)
            next_word[i] = rule[{w_ext[i], w_ext[i+1], w_ext[i+2]}];
    end
endmodule

// File: rtl/ca_frame_generator.sv
// ca_frame_generator: evolves a wrapping 1-D cellular automaton row by row and
// streams each frame into frame memory port A, one word per cycle.
module ca_frame_generator #(
    parameter int WORD_W        = ca_pkg::WORD_W,
    parameter int WORDS_PER_ROW = ca_pkg::WORDS_PER_ROW,
    parameter int ROWS          = ca_pkg::ROWS,
    parameter int ADDR_W        = 16
) (
    input  logic              clk108,
    input  logic              reset_n,
    input  logic              ready_sig,
    input  logic [7:0]        rule,
    input  logic              restart,
    output logic [ADDR_W-1:0] address_a,
    output logic [WORD_W-1:0] data_a,
    output logic              wren_a,
    output logic              busy,
    output logic              overrun
);
    import ca_pkg::*;
    localparam int WB = $clog2(WORDS_PER_ROW);
    localparam int RB = $clog2(ROWS);
    state_t r_state, w_next;
    logic [WORD_W-1:0] r_buf [WORDS_PER_ROW];
    logic [WB-1:0]     r_word;
    logic [RB-1:0]     r_row;
    logic [7:0]        r_rule;
    logic              r_ready_q, r_boot, r_first, r_pend, r_prev_msb, r_w0_lsb;
    logic              w_rise, w_start, w_row_end, w_last, w_left, w_right;
    logic [WORD_W-1:0] w_old, w_calc, w_data;
    logic [ADDR_W-1:0] w_addr;

    assign w_rise    = ready_sig & ~r_ready_q;
    assign w_start   = (r_state == IDLE) && (r_boot || w_rise);
    assign w_row_end = r_word == WB'(WORDS_PER_ROW - 1);
    assign w_last    = w_row_end && (r_row == RB'(ROWS - 1));
    assign w_old     = r_buf[r_word];
    // Word 0 reads the not-yet-updated last word; the last word reads the saved old bit 0 of word 0.
    assign w_left    = (r_word == '0) ? r_buf[WORDS_PER_ROW-1][WORD_W-1] : r_prev_msb;
    assign w_right   = w_row_end ? r_w0_lsb : r_buf[r_word + 1'b1][0];
    assign w_data    = (r_first && r_row == '0) ? w_old : w_calc;
    assign w_addr    = ADDR_W'(r_row) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(r_word);

    ca_word_next #(.WORD_W(WORD_W)) u_next (
        .rule(r_rule), .old_word(w_old), .left_bit(w_left), .right_bit(w_right), .next_word(w_calc)
    );

    always_ff @(posedge clk108 or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_start ? GEN : IDLE) : (w_last ? IDLE : GEN);
    end

    always_ff @(posedge clk108 or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < WORDS_PER_ROW; j++)
                r_buf[j] <= (j == SEED_WORD_IDX) ? WORD_W'(SEED_WORD) : '0;
            r_word     <= '0;
            r_row      <= '0;
            r_rule     <= '0;
            r_ready_q  <= 1'b0;
            r_boot     <= 1'b1;
            r_first    <= 1'b1;
            r_pend     <= 1'b0;
            r_prev_msb <= 1'b0;
            r_w0_lsb   <= 1'b0;
            address_a  <= '0;
            data_a     <= '0;
            wren_a     <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_ready_q <= ready_sig;
            r_boot    <= 1'b0;
            busy      <= (w_next == GEN) || (r_state == GEN);
            wren_a    <= (r_state == GEN);
            address_a <= (r_state == GEN) ? w_addr : '0;
            data_a    <= (r_state == GEN) ? w_data : '0;
            if (restart) r_pend <= 1'b1;
            if (r_state == GEN && w_rise) overrun <= 1'b1;
            // A restart is held until the next frame starts so the frame in flight is untouched.
            if (w_start) begin
                r_rule <= rule;
                r_word <= '0;
                r_row  <= '0;
                if (r_pend || restart) begin
                    for (int j = 0; j < WORDS_PER_ROW; j++)
                        r_buf[j] <= (j == SEED_WORD_IDX) ? WORD_W'(SEED_WORD) : '0;
                    r_first <= 1'b1;
                    r_pend  <= 1'b0;
                end
            end
            if (r_state == GEN) begin
                r_buf[r_word] <= w_data;
                r_prev_msb    <= w_old[WORD_W-1];
                if (r_word == '0) r_w0_lsb <= w_old[0];
                r_word <= w_row_end ? '0 : r_word + 1'b1;
                if (w_row_end) r_row <= r_row + 1'b1;
                if (w_last) r_first <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ca_frame_generator.sv
// tb_ca_frame_generator: directed frame-level checks on a reduced geometry
// (4-cell words, 64 words/row, 132 rows; seed cell 128).
module tb_ca_frame_generator;
    localparam int WW    = 4;
    localparam int WPR   = 64;
    localparam int RR    = 132;
    localparam int AW    = 16;
    localparam int FRAME = WPR * RR;

    logic          clk108 = 1'b0;
    logic          reset_n, ready_sig, restart;
    logic [7:0]    rule;
    logic [AW-1:0] address_a;
    logic [WW-1:0] data_a;
    logic          wren_a, busy, overrun;

    ca_frame_generator #(.WORD_W(WW), .WORDS_PER_ROW(WPR), .ROWS(RR), .ADDR_W(AW)) dut (
        .clk108(clk108), .reset_n(reset_n), .ready_sig(ready_sig), .rule(rule), .restart(restart),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .busy(busy), .overrun(overrun)
    );

    always #5 clk108 = ~clk108;

    typedef struct { int fr; int addr; int data; } vec_t;
    vec_t vt [19];

    int total = 0, passed = 0;
    int frames = 0, nwr = 0, seq_err = 0, m_prev_addr = 0;
    logic m_prev = 1'b0;
    logic [WW-1:0] mem [65536];

    // Write monitor: captures every frame into mem and checks the address stream.
    always @(negedge clk108) begin
        if (wren_a) begin
            if (!m_prev) begin
                frames = frames + 1;
                nwr = 1;
                seq_err = (address_a != 0) ? 1 : 0;
            end else begin
                nwr = nwr + 1;
                if (int'(address_a) != m_prev_addr + 1) seq_err = seq_err + 1;
            end
            mem[address_a] = data_a;
            m_prev_addr = int'(address_a);
        end
        m_prev = wren_a;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk108);
    endtask

    function automatic int nz(input int lo, input int hi);
        int c = 0;
        for (int a = lo; a <= hi; a++) if (mem[a] != 0) c++;
        return c;
    endfunction

    task automatic wait_done(input int f0, input string nm);
        int t = 0;
        while (!(frames > f0 && !wren_a) && t < 20000) begin
            tick(1);
            t++;
        end
        chk({nm, "_timeout"}, int'(t < 20000), 1);
        chk({nm, "_writes"}, nwr, FRAME);
        chk({nm, "_seq_err"}, seq_err, 0);
        chk({nm, "_busy_end"}, int'(busy), 0);
        chk({nm, "_addr_end"}, int'(address_a), 0);
    endtask

    task automatic table_check(input int f);
        for (int i = 0; i < 19; i++)
            if (vt[i].fr == f)
                chk($sformatf("f%0d_a%0d", f, vt[i].addr), int'(mem[vt[i].addr]), vt[i].data);
    endtask

    task automatic latency(input string nm);
        tick(1);
        chk({nm, "_busy_k"}, int'(busy), 1);
        chk({nm, "_wren_k"}, int'(wren_a), 0);
        tick(1);
        chk({nm, "_wren_k1"}, int'(wren_a), 1);
        chk({nm, "_addr_k1"}, int'(address_a), 0);
    endtask

    initial begin
        int f0, t;
        vt = '{'{1, 32, 1}, '{1, 95, 8}, '{1, 96, 2}, '{1, 159, 4}, '{1, 160, 4}, '{1, 0, 0},
               '{4, 32, 1}, '{4, 95, 8}, '{4, 8192, 1}, '{4, 8319, 8}, '{4, 8318, 0},
               '{5, 63, 4}, '{5, 127, 8}, '{5, 128, 1}, '{5, 192, 2}, '{5, 32, 0},
               '{6, 32, 1}, '{6, 95, 8}, '{6, 96, 2}};
        reset_n = 1'b0; ready_sig = 1'b0; restart = 1'b0; rule = 8'd90;
        tick(3);
        chk("rst_addr", int'(address_a), 0);
        chk("rst_data", int'(data_a), 0);
        chk("rst_wren", int'(wren_a), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        // Frame 1: boot start, rule 90 from the seed.
        reset_n = 1'b1;
        f0 = frames;
        latency("f1");
        wait_done(f0, "f1");
        table_check(1);
        chk("f1_row0_nz", nz(0, WPR - 1), 1);
        // Frame 2: rule 0 on a ready_sig edge.
        rule = 8'd0; ready_sig = 1'b1;
        f0 = frames;
        latency("f2");
        ready_sig = 1'b0;
        wait_done(f0, "f2");
        chk("f2_nz", nz(0, FRAME - 1), 0);
        // Frame 3: restart and a frame request while busy.
        rule = 8'd2; ready_sig = 1'b1;
        f0 = frames;
        tick(5);
        ready_sig = 1'b0;
        tick(495);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(500);
        ready_sig = 1'b1;
        tick(2);
        chk("f3_overrun", int'(overrun), 1);
        wait_done(f0, "f3");
        chk("f3_nz", nz(0, FRAME - 1), 0);
        tick(20);
        chk("f3_no_restart_wren", int'(wren_a), 0);
        chk("f3_no_restart_busy", int'(busy), 0);
        chk("f3_frames", frames, f0 + 1);
        chk("f3_overrun_hold", int'(overrun), 1);
        // Frame 4: rule 2 from the reloaded seed, right wrap.
        ready_sig = 1'b0;
        tick(2);
        ready_sig = 1'b1;
        f0 = frames;
        wait_done(f0, "f4");
        table_check(4);
        chk("f4_row0_nz", nz(0, WPR - 1), 1);
        // Frame 5: rule 16 continues from frame 4, left wrap; mid-frame rule change ignored.
        ready_sig = 1'b0;
        tick(2);
        rule = 8'd16; ready_sig = 1'b1;
        f0 = frames;
        tick(100);
        rule = 8'd0;
        wait_done(f0, "f5");
        table_check(5);
        chk("f5_overrun", int'(overrun), 1);
        // Frame 6: reset mid-frame, then restart from the seed.
        ready_sig = 1'b0;
        tick(2);
        rule = 8'd90; ready_sig = 1'b1;
        tick(5);
        ready_sig = 1'b0;
        t = 0;
        while (!(wren_a && address_a == 3000) && t < 20000) begin
            tick(1);
            t++;
        end
        chk("f6_reach_3000", int'(t < 20000), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_addr", int'(address_a), 0);
        chk("mid_rst_data", int'(data_a), 0);
        chk("mid_rst_wren", int'(wren_a), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_overrun", int'(overrun), 0);
        tick(2);
        reset_n = 1'b1;
        f0 = frames;
        latency("f6");
        wait_done(f0, "f6");
        table_check(6);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
